// File: rtl/inference_loader.sv
// Frame loader for the inference core: streams AXI-Stream words into the A, B and C operand RAMs,
// fires a one-cycle Start once the last C word is written, then holds off input until Done.
module inference_loader #(
  parameter int unsigned width        = 8,
  parameter int unsigned A_depth_bits = 9,
  parameter int unsigned B_depth_bits = 4,
  parameter int unsigned C_depth_bits = 2,
  parameter int unsigned A_words      = 448,
  parameter int unsigned B_words      = 16,
  parameter int unsigned C_words      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  input  logic                    S_AXIS_TLAST,
  output logic                    S_AXIS_TREADY,
  output logic                    A_write_en,
  output logic [A_depth_bits-1:0] A_write_address,
  output logic [width-1:0]        A_write_data_in,
  output logic                    B_write_en,
  output logic [B_depth_bits-1:0] B_write_address,
  output logic [width-1:0]        B_write_data_in,
  output logic                    C_write_en,
  output logic [C_depth_bits-1:0] C_write_address,
  output logic [width-1:0]        C_write_data_in,
  output logic                    Start,
  input  logic                    Done,
  output logic                    busy,
  output logic                    frame_error
);

  localparam int unsigned CntW = $clog2(A_words);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StLoadC,
    StFire,
    StWaitDone
  } state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic                    busy_q, busy_d;
  logic                    frame_error_q, frame_error_d;
  logic                    start_q, start_d;
  logic                    a_we_q, a_we_d;
  logic [A_depth_bits-1:0] a_addr_q, a_addr_d;
  logic [width-1:0]        a_data_q, a_data_d;
  logic                    b_we_q, b_we_d;
  logic [B_depth_bits-1:0] b_addr_q, b_addr_d;
  logic [width-1:0]        b_data_q, b_data_d;
  logic                    c_we_q, c_we_d;
  logic [C_depth_bits-1:0] c_addr_q, c_addr_d;
  logic [width-1:0]        c_data_q, c_data_d;

  logic             loading;
  logic             xfer;
  logic [width-1:0] word;

  assign loading = (state_q == StIdle) || (state_q == StLoadA) ||
                   (state_q == StLoadB) || (state_q == StLoadC);
  // Ready is gated by reset so no word is acknowledged while the block is being cleared.
  assign S_AXIS_TREADY = loading && !reset;
  assign xfer          = S_AXIS_TVALID && S_AXIS_TREADY;
  assign word          = S_AXIS_TDATA[width-1:0];

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    busy_d        = busy_q;
    frame_error_d = frame_error_q;
    start_d       = 1'b0;
    a_we_d        = 1'b0;
    a_addr_d      = a_addr_q;
    a_data_d      = a_data_q;
    b_we_d        = 1'b0;
    b_addr_d      = b_addr_q;
    b_data_d      = b_data_q;
    c_we_d        = 1'b0;
    c_addr_d      = c_addr_q;
    c_data_d      = c_data_q;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          a_we_d   = 1'b1;
          a_addr_d = '0;
          a_data_d = word;
          if (S_AXIS_TLAST) begin
            // A one-word frame is always short; nothing more to load.
            frame_error_d = 1'b1;
          end else begin
            busy_d  = 1'b1;
            count_d = CntW'(1);
            state_d = StLoadA;
          end
        end
      end
      StLoadA: begin
        if (xfer) begin
          a_we_d   = 1'b1;
          a_addr_d = count_q[A_depth_bits-1:0];
          a_data_d = word;
          if (S_AXIS_TLAST) begin
            frame_error_d = 1'b1;
            busy_d        = 1'b0;
            count_d       = '0;
            state_d       = StIdle;
          end else if (count_q == CntW'(A_words - 1)) begin
            count_d = '0;
            state_d = StLoadB;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StLoadB: begin
        if (xfer) begin
          b_we_d   = 1'b1;
          b_addr_d = count_q[B_depth_bits-1:0];
          b_data_d = word;
          if (S_AXIS_TLAST) begin
            frame_error_d = 1'b1;
            busy_d        = 1'b0;
            count_d       = '0;
            state_d       = StIdle;
          end else if (count_q == CntW'(B_words - 1)) begin
            count_d = '0;
            state_d = StLoadC;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StLoadC: begin
        if (xfer) begin
          c_we_d   = 1'b1;
          c_addr_d = count_q[C_depth_bits-1:0];
          c_data_d = word;
          if (count_q == CntW'(C_words - 1)) begin
            // A missing TLAST on the final word is flagged but the frame is still used.
            if (!S_AXIS_TLAST) frame_error_d = 1'b1;
            count_d = '0;
            state_d = StFire;
          end else if (S_AXIS_TLAST) begin
            frame_error_d = 1'b1;
            busy_d        = 1'b0;
            count_d       = '0;
            state_d       = StIdle;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
      end
      StFire: begin
        start_d = 1'b1;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (Done) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        count_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      count_q       <= '0;
      busy_q        <= 1'b0;
      frame_error_q <= 1'b0;
      start_q       <= 1'b0;
      a_we_q        <= 1'b0;
      a_addr_q      <= '0;
      a_data_q      <= '0;
      b_we_q        <= 1'b0;
      b_addr_q      <= '0;
      b_data_q      <= '0;
      c_we_q        <= 1'b0;
      c_addr_q      <= '0;
      c_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      busy_q        <= busy_d;
      frame_error_q <= frame_error_d;
      start_q       <= start_d;
      a_we_q        <= a_we_d;
      a_addr_q      <= a_addr_d;
      a_data_q      <= a_data_d;
      b_we_q        <= b_we_d;
      b_addr_q      <= b_addr_d;
      b_data_q      <= b_data_d;
      c_we_q        <= c_we_d;
      c_addr_q      <= c_addr_d;
      c_data_q      <= c_data_d;
    end
  end

  assign A_write_en      = a_we_q;
  assign A_write_address = a_addr_q;
  assign A_write_data_in = a_data_q;
  assign B_write_en      = b_we_q;
  assign B_write_address = b_addr_q;
  assign B_write_data_in = b_data_q;
  assign C_write_en      = c_we_q;
  assign C_write_address = c_addr_q;
  assign C_write_data_in = c_data_q;
  assign Start           = start_q;
  assign busy            = busy_q;
  assign frame_error     = frame_error_q;

endmodule

// File: tb/tb_inference_loader.sv
// Directed bench for inference_loader: full frames, gapped input, Done blocking, TLAST errors
// and mid-frame reset.
module tb_inference_loader;

  localparam int FrameLen = 467;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TVALID;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TREADY;
  logic        A_write_en;
  logic [8:0]  A_write_address;
  logic [7:0]  A_write_data_in;
  logic        B_write_en;
  logic [3:0]  B_write_address;
  logic [7:0]  B_write_data_in;
  logic        C_write_en;
  logic [1:0]  C_write_address;
  logic [7:0]  C_write_data_in;
  logic        Start;
  logic        Done;
  logic        busy;
  logic        frame_error;

  always #5 clk = ~clk;

  inference_loader dut (
    .clk             (clk),
    .reset           (reset),
    .S_AXIS_TDATA    (S_AXIS_TDATA),
    .S_AXIS_TVALID   (S_AXIS_TVALID),
    .S_AXIS_TLAST    (S_AXIS_TLAST),
    .S_AXIS_TREADY   (S_AXIS_TREADY),
    .A_write_en      (A_write_en),
    .A_write_address (A_write_address),
    .A_write_data_in (A_write_data_in),
    .B_write_en      (B_write_en),
    .B_write_address (B_write_address),
    .B_write_data_in (B_write_data_in),
    .C_write_en      (C_write_en),
    .C_write_address (C_write_address),
    .C_write_data_in (C_write_data_in),
    .Start           (Start),
    .Done            (Done),
    .busy            (busy),
    .frame_error     (frame_error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int stalls = 0;
  int onehot_err = 0;
  int c_last_cyc = -100;
  int a_addr_log[$], a_data_log[$];
  int b_addr_log[$], b_data_log[$];
  int c_addr_log[$], c_data_log[$];
  int start_log[$];

  // Write-port monitor, sampled between the active edge and the stimulus edge.
  always @(posedge clk) begin
    #2;
    cyc++;
    if (A_write_en) begin
      a_addr_log.push_back(int'(A_write_address));
      a_data_log.push_back(int'(A_write_data_in));
    end
    if (B_write_en) begin
      b_addr_log.push_back(int'(B_write_address));
      b_data_log.push_back(int'(B_write_data_in));
    end
    if (C_write_en) begin
      c_addr_log.push_back(int'(C_write_address));
      c_data_log.push_back(int'(C_write_data_in));
      if (C_write_address == 2'd2) c_last_cyc = cyc;
    end
    if (Start) start_log.push_back(cyc);
    if ((int'(A_write_en) + int'(B_write_en) + int'(C_write_en)) > 1) onehot_err++;
  end

  task automatic clear_logs();
    a_addr_log.delete(); a_data_log.delete();
    b_addr_log.delete(); b_data_log.delete();
    c_addr_log.delete(); c_data_log.delete();
    start_log.delete();
    stalls = 0;
    c_last_cyc = -100;
  endtask

  // Number of entries in the write logs that differ from one clean 467-word frame.
  function automatic int frame_bad();
    int bad = 0;
    if (a_addr_log.size() != 448) bad++;
    if (b_addr_log.size() != 16) bad++;
    if (c_addr_log.size() != 3) bad++;
    foreach (a_addr_log[i]) if (a_addr_log[i] != i || a_data_log[i] != (i % 256)) bad++;
    foreach (b_addr_log[i]) if (b_addr_log[i] != i || b_data_log[i] != ((448 + i) % 256)) bad++;
    foreach (c_addr_log[i]) if (c_addr_log[i] != i || c_data_log[i] != ((464 + i) % 256)) bad++;
    return bad;
  endfunction

  task automatic send_word(input int idx, input bit last);
    int k;
    logic [31:0] upper;
    @(negedge clk);
    upper         = $urandom();
    S_AXIS_TDATA  = (upper << 8) | 32'(idx & 255);
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    k = 0;
    while (!S_AXIS_TREADY && k < 50) begin
      stalls++;
      @(negedge clk);
      k++;
    end
    if (k == 50) begin
      tests++;
      fails++;
      $display("FAIL send_word timeout idx=%0d tready=%b required 1", idx, S_AXIS_TREADY);
    end
  endtask

  task automatic send_frame(input int n, input int tlast_at, input bit gap);
    for (int i = 0; i < n; i++) begin
      if (gap && i > 0) begin
        @(negedge clk);
        S_AXIS_TVALID = 1'b0;
        if (!S_AXIS_TREADY) stalls++;
      end
      send_word(i, i == tlast_at);
    end
    @(negedge clk);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    Done = 1'b1;
    @(negedge clk);
    Done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    S_AXIS_TVALID = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (S_AXIS_TREADY !== 1'b0) begin
      fails++; $display("FAIL reset_tready got %b want 0", S_AXIS_TREADY);
    end
    tests++;
    if ({A_write_en, B_write_en, C_write_en} !== 3'b000) begin
      fails++; $display("FAIL reset_we got %b want 000", {A_write_en, B_write_en, C_write_en});
    end
    tests++;
    if ({A_write_address, B_write_address, C_write_address} !== 15'd0 ||
        {A_write_data_in, B_write_data_in, C_write_data_in} !== 24'd0) begin
      fails++; $display("FAIL reset_addr_data got %h/%h want 0",
                        {A_write_address, B_write_address, C_write_address},
                        {A_write_data_in, B_write_data_in, C_write_data_in});
    end
    tests++;
    if ({Start, busy, frame_error} !== 3'b000) begin
      fails++; $display("FAIL reset_flags got %b want 000", {Start, busy, frame_error});
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (S_AXIS_TREADY !== 1'b1) begin
      fails++; $display("FAIL idle_tready got %b want 1", S_AXIS_TREADY);
    end
  endtask

  task automatic test_full_frame();
    int bad;
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b0);
    repeat (4) @(negedge clk);
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL full_writes got %0d bad entries want 0", bad); end
    tests++;
    if (start_log.size() !== 1) begin
      fails++; $display("FAIL full_start_count got %0d want 1", start_log.size());
    end else begin
      tests++;
      if (start_log[0] !== c_last_cyc + 1) begin
        fails++; $display("FAIL full_start_timing got cyc %0d want %0d", start_log[0], c_last_cyc + 1);
      end
    end
    tests++;
    if (frame_error !== 1'b0) begin fails++; $display("FAIL full_frame_error got %b want 0", frame_error); end
    tests++;
    if (stalls !== 0) begin fails++; $display("FAIL full_stalls got %0d want 0", stalls); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL full_busy got %b want 1", busy); end
    pulse_done();
  endtask

  task automatic test_gapped_frame();
    int bad;
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b1);
    repeat (4) @(negedge clk);
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL gap_writes got %0d bad entries want 0", bad); end
    tests++;
    if (start_log.size() !== 1) begin
      fails++; $display("FAIL gap_start_count got %0d want 1", start_log.size());
    end
    tests++;
    if (stalls !== 0) begin fails++; $display("FAIL gap_tready_low got %0d cycles want 0", stalls); end
    pulse_done();
  endtask

  task automatic test_back_to_back();
    int bad;
    int ready_hi;
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b0);
    repeat (3) @(negedge clk);
    ready_hi = 0;
    S_AXIS_TVALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (S_AXIS_TREADY) ready_hi++;
    end
    tests++;
    if (ready_hi !== 0) begin fails++; $display("FAIL wait_tready got %0d high cycles want 0", ready_hi); end
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL wait_no_writes got %0d bad entries want 0", bad); end
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL wait_busy got %b want 1", busy); end
    Done = 1'b1;
    @(negedge clk);
    Done = 1'b0;
    S_AXIS_TVALID = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL done_busy got %b want 0", busy); end
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b0);
    repeat (4) @(negedge clk);
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL second_frame got %0d bad entries want 0", bad); end
    tests++;
    if (start_log.size() !== 1) begin
      fails++; $display("FAIL second_start_count got %0d want 1", start_log.size());
    end
    pulse_done();
  endtask

  task automatic test_early_tlast();
    int bad;
    clear_logs();
    send_frame(101, 100, 1'b0);
    repeat (6) @(negedge clk);
    tests++;
    if (frame_error !== 1'b1) begin fails++; $display("FAIL early_frame_error got %b want 1", frame_error); end
    tests++;
    if (start_log.size() !== 0) begin
      fails++; $display("FAIL early_no_start got %0d starts want 0", start_log.size());
    end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL early_busy got %b want 0", busy); end
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b0);
    repeat (4) @(negedge clk);
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL after_error_frame got %0d bad entries want 0", bad); end
    tests++;
    if (start_log.size() !== 1) begin
      fails++; $display("FAIL after_error_start got %0d want 1", start_log.size());
    end
    tests++;
    if (frame_error !== 1'b1) begin fails++; $display("FAIL error_sticky got %b want 1", frame_error); end
    pulse_done();
  endtask

  task automatic test_missing_tlast();
    do_reset();
    clear_logs();
    tests++;
    if (frame_error !== 1'b0) begin fails++; $display("FAIL err_cleared got %b want 0", frame_error); end
    send_frame(FrameLen, -1, 1'b0);
    repeat (4) @(negedge clk);
    tests++;
    if (frame_error !== 1'b1) begin fails++; $display("FAIL missing_tlast_err got %b want 1", frame_error); end
    tests++;
    if (start_log.size() !== 1) begin
      fails++; $display("FAIL missing_tlast_start got %0d want 1", start_log.size());
    end
    pulse_done();
  endtask

  task automatic test_mid_reset();
    int bad;
    do_reset();
    clear_logs();
    send_frame(300, -1, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({S_AXIS_TREADY, A_write_en, B_write_en, C_write_en, Start, busy, frame_error} !== 7'd0) begin
      fails++; $display("FAIL midreset_outputs got %b want 0000000",
                        {S_AXIS_TREADY, A_write_en, B_write_en, C_write_en, Start, busy, frame_error});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (start_log.size() !== 0) begin
      fails++; $display("FAIL midreset_no_start got %0d want 0", start_log.size());
    end
    clear_logs();
    send_frame(FrameLen, FrameLen - 1, 1'b0);
    repeat (4) @(negedge clk);
    bad = frame_bad();
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL post_reset_frame got %0d bad entries want 0", bad); end
    tests++;
    if (start_log.size() !== 1 || frame_error !== 1'b0) begin
      fails++; $display("FAIL post_reset_start got %0d starts err=%b want 1 starts err=0",
                        start_log.size(), frame_error);
    end
    pulse_done();
    tests++;
    if (onehot_err !== 0) begin fails++; $display("FAIL onehot_we got %0d cycles want 0", onehot_err); end
  endtask

  initial begin
    reset         = 1'b1;
    S_AXIS_TDATA  = '0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    Done          = 1'b0;
    test_reset();
    test_full_frame();
    test_gapped_frame();
    test_back_to_back();
    test_early_tlast();
    test_missing_tlast();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
